// File: rtl/rab_port_arb_fsm_if.sv
// Signal bundle between the requesting address channels, the RAB lookup and the
// port arbiter FSM. The FSM uses the slave view; the requester/lookup side uses master.
interface rab_port_arb_fsm_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic [NUM_PORTS-1:0]  port_addr_valid;
    logic [NUM_PORTS-1:0]  port_skip;
    logic [NUM_PORTS-1:0]  port_sent;
    logic                  no_hit;
    logic                  multiple_hit;
    logic                  no_prot;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  master_select;
    logic                  cnt_clr;

    logic [NUM_PORTS-1:0]  grant;
    logic                  busy;
    logic [NUM_PORTS-1:0]  port_accept;
    logic [NUM_PORTS-1:0]  port_drop;
    logic [ADDR_WIDTH-1:0] out_addr_reg;
    logic                  master_select_reg;
    logic                  int_miss;
    logic                  int_multi;
    logic                  int_prot;
    logic [CNT_WIDTH-1:0]  miss_cnt;

    modport slave (
        input  port_addr_valid, port_skip, port_sent,
        input  no_hit, multiple_hit, no_prot, out_addr, master_select, cnt_clr,
        output grant, busy, port_accept, port_drop, out_addr_reg, master_select_reg,
        output int_miss, int_multi, int_prot, miss_cnt
    );

    modport master (
        output port_addr_valid, port_skip, port_sent,
        output no_hit, multiple_hit, no_prot, out_addr, master_select, cnt_clr,
        input  grant, busy, port_accept, port_drop, out_addr_reg, master_select_reg,
        input  int_miss, int_multi, int_prot, miss_cnt
    );
endinterface

// File: rtl/rab_port_arb_fsm.sv
// Round-robin N-port RAB control FSM: grants one address channel, waits LOOKUP_LAT
// cycles for the lookup, pulses accept/drop plus interrupts, then waits for sent.
module rab_port_arb_fsm #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LOOKUP_LAT = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    rab_port_arb_fsm_if.slave bus
);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam int LAT_W = $clog2(LOOKUP_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    state_e                r_state,       w_state_nxt;
    logic [NUM_PORTS-1:0]  r_grant,       w_grant_nxt;
    logic [PTR_W-1:0]      r_gnt_idx,     w_gnt_idx_nxt;
    logic [PTR_W-1:0]      r_rr_ptr,      w_rr_ptr_nxt;
    logic [LAT_W-1:0]      r_lat_cnt,     w_lat_cnt_nxt;
    logic                  r_busy,        w_busy_nxt;
    logic [NUM_PORTS-1:0]  r_accept,      w_accept_nxt;
    logic [NUM_PORTS-1:0]  r_drop,        w_drop_nxt;
    logic [ADDR_WIDTH-1:0] r_out_addr,    w_out_addr_nxt;
    logic                  r_msel,        w_msel_nxt;
    logic                  r_int_miss,    w_int_miss_nxt;
    logic                  r_int_multi,   w_int_multi_nxt;
    logic                  r_int_prot,    w_int_prot_nxt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt,    w_miss_cnt_nxt;

    logic                  w_arb_hit;
    logic [PTR_W-1:0]      w_arb_idx;
    logic [SUM_W-1:0]      w_sum;
    logic [PTR_W-1:0]      w_cand;
    logic                  w_err;
    logic                  w_skip;
    logic                  w_sample;

    // First requester at or after r_rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin : p_arb
        w_arb_hit = 1'b0;
        w_arb_idx = '0;
        w_sum     = '0;
        w_cand    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_sum = {1'b0, r_rr_ptr} + SUM_W'(i);
            if (w_sum >= SUM_W'(NUM_PORTS)) w_sum = w_sum - SUM_W'(NUM_PORTS);
            w_cand = w_sum[PTR_W-1:0];
            if (!w_arb_hit && bus.port_addr_valid[w_cand]) begin
                w_arb_hit = 1'b1;
                w_arb_idx = w_cand;
            end
        end
    end

    // NOTE: state and outputs share one clocked process with non-blocking updates so
    // every register sees pre-edge values; all combinational logic lives in always_comb.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin : p_state
        if (!s_axi_aresetn) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_gnt_idx   <= '0;
            r_rr_ptr    <= '0;
            r_lat_cnt   <= '0;
            r_busy      <= 1'b0;
            r_accept    <= '0;
            r_drop      <= '0;
            r_out_addr  <= '0;
            r_msel      <= 1'b0;
            r_int_miss  <= 1'b0;
            r_int_multi <= 1'b0;
            r_int_prot  <= 1'b0;
            r_miss_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_busy      <= w_busy_nxt;
            r_accept    <= w_accept_nxt;
            r_drop      <= w_drop_nxt;
            r_out_addr  <= w_out_addr_nxt;
            r_msel      <= w_msel_nxt;
            r_int_miss  <= w_int_miss_nxt;
            r_int_multi <= w_int_multi_nxt;
            r_int_prot  <= w_int_prot_nxt;
            r_miss_cnt  <= w_miss_cnt_nxt;
        end
    end

    assign w_sample = (r_state == ST_LOOKUP) && (r_lat_cnt == LAT_W'(1));

    always_comb begin : p_next
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_arb_hit) w_state_nxt = ST_LOOKUP;
            ST_LOOKUP: if (w_sample) w_state_nxt = ST_WAIT;
            ST_WAIT:   if (bus.port_sent[r_gnt_idx]) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default before the case so that no
    // path leaves a variable unassigned and infers a latch.
    always_comb begin : p_out
        w_grant_nxt     = r_grant;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_accept_nxt    = '0;
        w_drop_nxt      = '0;
        w_out_addr_nxt  = r_out_addr;
        w_msel_nxt      = r_msel;
        w_int_miss_nxt  = 1'b0;
        w_int_multi_nxt = 1'b0;
        w_int_prot_nxt  = 1'b0;
        w_miss_cnt_nxt  = r_miss_cnt;
        w_err  = bus.no_hit | bus.multiple_hit | ~bus.no_prot;
        w_skip = bus.port_skip[r_gnt_idx];

        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                if (w_arb_hit) begin
                    w_grant_nxt[w_arb_idx] = 1'b1;
                    w_gnt_idx_nxt          = w_arb_idx;
                    w_lat_cnt_nxt          = LAT_W'(LOOKUP_LAT);
                end
            end
            ST_LOOKUP: begin
                w_lat_cnt_nxt = r_lat_cnt - LAT_W'(1);
                if (w_sample) begin
                    w_drop_nxt[r_gnt_idx]   = w_skip | w_err;
                    w_accept_nxt[r_gnt_idx] = ~(w_skip | w_err);
                    w_int_miss_nxt          = ~w_skip & bus.no_hit;
                    w_int_multi_nxt         = ~w_skip & bus.multiple_hit;
                    w_int_prot_nxt          = ~w_skip & ~bus.no_prot;
                    w_out_addr_nxt          = bus.out_addr;
                    w_msel_nxt              = bus.master_select;
                end
            end
            ST_WAIT: begin
                if (bus.port_sent[r_gnt_idx]) begin
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = (r_gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0
                                                                       : r_gnt_idx + PTR_W'(1);
                end
            end
            default: w_grant_nxt = '0;
        endcase

        // Clear wins over a simultaneous miss.
        if (bus.cnt_clr)
            w_miss_cnt_nxt = '0;
        else if (w_int_miss_nxt && (r_miss_cnt != {CNT_WIDTH{1'b1}}))
            w_miss_cnt_nxt = r_miss_cnt + CNT_WIDTH'(1);

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign bus.grant             = r_grant;
    assign bus.busy              = r_busy;
    assign bus.port_accept       = r_accept;
    assign bus.port_drop         = r_drop;
    assign bus.out_addr_reg      = r_out_addr;
    assign bus.master_select_reg = r_msel;
    assign bus.int_miss          = r_int_miss;
    assign bus.int_multi         = r_int_multi;
    assign bus.int_prot          = r_int_prot;
    assign bus.miss_cnt          = r_miss_cnt;
endmodule
